// File: rtl/vend_ctrl.sv
// Vending transaction controller: collects coin credit, vends at PRICE, returns change as pulses.
// Optional: define VEND_TIMEOUT_EN to auto-refund after TIMEOUT idle cycles in COLLECT.
module vend_ctrl #(
  parameter int unsigned PRICE       = 5,
  parameter int unsigned MAX_CREDIT  = 20,
  parameter int unsigned DISP_CYCLES = 50_000_000,
  parameter int unsigned CHG_GAP     = 25_000_000,
  parameter int unsigned TIMEOUT     = 500_000_000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       flag_half,
  input  logic       val_half,
  input  logic       flag_one,
  input  logic       val_one,
  input  logic       flag_cancel,
  input  logic       val_cancel,
  output logic [7:0] credit,
  output logic       dispense,
  output logic       change_pulse,
  output logic       coin_reject,
  output logic       busy
);
  // state      | meaning
  // S_IDLE     | no credit held, waiting for a coin
  // S_COLLECT  | partial credit held, below PRICE
  // S_DISPENSE | dispense held high for DISP_CYCLES cycles
  // S_CHANGE   | credit returned as a change_pulse train
  typedef enum logic [1:0] {S_IDLE, S_COLLECT, S_DISPENSE, S_CHANGE} state_t;

  state_t      r_state, w_state_nxt;
  logic [7:0]  r_credit, w_credit_nxt;
  logic [31:0] r_timer, w_timer_nxt;
  logic        r_dispense, w_dispense_nxt;
  logic        r_change, w_change_nxt;
  logic        r_reject, w_reject_nxt;
  logic        r_busy;

  logic        w_half_evt, w_one_evt, w_cancel_evt;
  logic [1:0]  w_coin_val;
  logic [8:0]  w_sum;
  logic        w_coin, w_over, w_acc, w_tmo;
  logic        w_go_chg;
  logic [7:0]  w_refund;

  assign w_half_evt   = flag_half & ~val_half;
  assign w_one_evt    = flag_one & ~val_one;
  assign w_cancel_evt = flag_cancel & ~val_cancel;
  assign w_coin_val   = {w_one_evt, w_half_evt};
  assign w_coin       = |w_coin_val;
  assign w_sum        = {1'b0, r_credit} + {7'd0, w_coin_val};
  assign w_over       = w_sum > 9'(MAX_CREDIT);
  assign w_acc        = w_coin & ~w_over & ((r_state == S_IDLE) | (r_state == S_COLLECT));

`ifdef VEND_TIMEOUT_EN
  logic [31:0] r_idle_cnt;

  assign w_tmo = (r_state == S_COLLECT) && !w_acc && (r_idle_cnt == 32'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if ((r_state == S_COLLECT) && (w_state_nxt == S_COLLECT) && !w_acc) begin
      r_idle_cnt <= r_idle_cnt + 32'd1;
    end else begin
      r_idle_cnt <= '0;
    end
  end
`else
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_state_nxt    = r_state;
    w_credit_nxt   = r_credit;
    w_timer_nxt    = r_timer;
    w_dispense_nxt = 1'b0;
    w_change_nxt   = 1'b0;
    w_reject_nxt   = 1'b0;
    w_go_chg       = 1'b0;
    w_refund       = r_credit;
    case (r_state)
      S_IDLE, S_COLLECT: begin
        w_reject_nxt = w_coin & w_over;
        if (w_acc) w_refund = w_sum[7:0];
        // a refund request outranks a vend that the same coin would trigger
        if (w_cancel_evt || w_tmo) begin
          w_go_chg = (w_refund != 8'd0);
        end else if (w_acc && (w_sum >= 9'(PRICE))) begin
          w_state_nxt    = S_DISPENSE;
          w_credit_nxt   = 8'(w_sum - 9'(PRICE));
          w_dispense_nxt = 1'b1;
          w_timer_nxt    = 32'(DISP_CYCLES - 1);
        end else if (w_acc) begin
          w_state_nxt  = S_COLLECT;
          w_credit_nxt = w_sum[7:0];
        end
      end
      S_DISPENSE: begin
        w_reject_nxt = w_coin;
        if (r_timer == 32'd0) begin
          if (r_credit != 8'd0) w_go_chg = 1'b1;
          else                  w_state_nxt = S_IDLE;
        end else begin
          w_timer_nxt    = r_timer - 32'd1;
          w_dispense_nxt = 1'b1;
        end
      end
      S_CHANGE: begin
        w_reject_nxt = w_coin;
        if (r_credit == 8'd0) begin
          w_state_nxt = S_IDLE;
        end else if (r_timer == 32'd0) begin
          w_change_nxt = 1'b1;
          w_credit_nxt = r_credit - 8'd1;
          w_timer_nxt  = 32'(CHG_GAP - 1);
        end else begin
          w_timer_nxt = r_timer - 32'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    // entering CHANGE emits the first pulse immediately
    if (w_go_chg) begin
      w_state_nxt  = S_CHANGE;
      w_change_nxt = 1'b1;
      w_credit_nxt = w_refund - 8'd1;
      w_timer_nxt  = 32'(CHG_GAP - 1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_credit   <= '0;
      r_timer    <= '0;
      r_dispense <= 1'b0;
      r_change   <= 1'b0;
      r_reject   <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_credit   <= w_credit_nxt;
      r_timer    <= w_timer_nxt;
      r_dispense <= w_dispense_nxt;
      r_change   <= w_change_nxt;
      r_reject   <= w_reject_nxt;
      r_busy     <= (w_state_nxt == S_DISPENSE) || (w_state_nxt == S_CHANGE);
    end
  end

  assign credit       = r_credit;
  assign dispense     = r_dispense;
  assign change_pulse = r_change;
  assign coin_reject  = r_reject;
  assign busy         = r_busy;
endmodule

// File: tb/tb_vend_ctrl.sv
// Bench for vend_ctrl: two instances (PRICE 5 and 20) share stimulus; a schedule-based model feeds a scoreboard.
module tb_vend_ctrl;
  localparam int D = 4, G = 3, TMO = 40, MAXC = 20;
  localparam int PRICE_A = 5, PRICE_B = 20;
`ifdef VEND_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flag_half = 1'b0, val_half = 1'b1;
  logic flag_one = 1'b0, val_one = 1'b1;
  logic flag_cancel = 1'b0, val_cancel = 1'b1;
  logic [7:0] credit_a, credit_b;
  logic dispense_a, change_pulse_a, coin_reject_a, busy_a;
  logic dispense_b, change_pulse_b, coin_reject_b, busy_b;

  always #5 clk = ~clk;

  vend_ctrl #(.PRICE(PRICE_A), .MAX_CREDIT(MAXC), .DISP_CYCLES(D), .CHG_GAP(G), .TIMEOUT(TMO)) u_dut_a (
    .clk(clk), .rst_n(rst_n),
    .flag_half(flag_half), .val_half(val_half), .flag_one(flag_one), .val_one(val_one),
    .flag_cancel(flag_cancel), .val_cancel(val_cancel),
    .credit(credit_a), .dispense(dispense_a), .change_pulse(change_pulse_a),
    .coin_reject(coin_reject_a), .busy(busy_a));

  vend_ctrl #(.PRICE(PRICE_B), .MAX_CREDIT(MAXC), .DISP_CYCLES(D), .CHG_GAP(G), .TIMEOUT(TMO)) u_dut_b (
    .clk(clk), .rst_n(rst_n),
    .flag_half(flag_half), .val_half(val_half), .flag_one(flag_one), .val_one(val_one),
    .flag_cancel(flag_cancel), .val_cancel(val_cancel),
    .credit(credit_b), .dispense(dispense_b), .change_pulse(change_pulse_b),
    .coin_reject(coin_reject_b), .busy(busy_b));

  typedef struct packed {
    logic [7:0] credit;
    logic       disp;
    logic       pulse;
    logic       rej;
    logic       busy;
  } vec_t;
  typedef struct {
    int   edge_n;
    vec_t v;
  } rec_t;

  rec_t exp_q[2][$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  int   price [2] = '{PRICE_A, PRICE_B};

  // model: idle credit, or a busy window described by start edge, vend flag and refund count
  int   m_credit [2];
  bit   m_busy [2];
  int   b_start [2], b_cnt [2], b_end [2], m_last_acc [2];
  bit   b_disp [2];
  vec_t prev_exp [2], prev_dut [2];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t dut_vec(int id);
    if (id == 0) return vec_t'({credit_a, dispense_a, change_pulse_a, coin_reject_a, busy_a});
    return vec_t'({credit_b, dispense_b, change_pulse_b, coin_reject_b, busy_b});
  endfunction

  function automatic vec_t sched(int id, int n);
    vec_t v;
    int ts;
    v  = '0;
    ts = b_start[id] + (b_disp[id] ? D : 0);
    if (n >= b_end[id]) return v;
    v.busy = 1'b1;
    if (b_disp[id] && n < ts) begin
      v.disp   = 1'b1;
      v.credit = 8'(b_cnt[id]);
    end else begin
      v.pulse  = ((n - ts) % G) == 0;
      v.credit = 8'(b_cnt[id] - 1 - (n - ts) / G);
    end
    return v;
  endfunction

  task automatic start_busy(int id, int n, bit disp, int cnt);
    int ts;
    m_busy[id]  = 1'b1;
    b_start[id] = n;
    b_disp[id]  = disp;
    b_cnt[id]   = cnt;
    ts          = n + (disp ? D : 0);
    b_end[id]   = (cnt > 0) ? ts + (cnt - 1) * G + 1 : ts;
    m_credit[id] = 0;
  endtask

  task automatic model_step(int id, int n);
    int v, s;
    bit acc, tmo, canc;
    vec_t e;
    rec_t r;
    v    = ((flag_half && !val_half) ? 1 : 0) + ((flag_one && !val_one) ? 2 : 0);
    canc = flag_cancel && !val_cancel;
    if (m_busy[id] && n > b_end[id]) begin
      m_busy[id]   = 1'b0;
      m_credit[id] = 0;
    end
    if (m_busy[id]) begin
      e     = sched(id, n);
      e.rej = (v > 0);
    end else begin
      acc = (v > 0) && (m_credit[id] + v <= MAXC);
      s   = m_credit[id] + (acc ? v : 0);
      tmo = TMO_EN && (m_credit[id] > 0) && !acc && (n - m_last_acc[id] == TMO);
      if ((canc || tmo) && s > 0) start_busy(id, n, 1'b0, s);
      else if (acc && s >= price[id]) start_busy(id, n, 1'b1, s - price[id]);
      else if (acc) begin
        m_credit[id]   = s;
        m_last_acc[id] = n;
      end
      e = m_busy[id] ? sched(id, n) : '0;
      if (!m_busy[id]) e.credit = 8'(m_credit[id]);
      e.rej = (v > 0) && !acc;
    end
    if (e != prev_exp[id]) begin
      r.edge_n = n;
      r.v      = e;
      exp_q[id].push_back(r);
    end
    prev_exp[id] = e;
  endtask

  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_credit[i] = 0; b_end[i] = 0; prev_exp[i] = '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) model_step(i, cyc + 1);
    end
  end

  always @(negedge clk) begin
    vec_t dv;
    rec_t r;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) prev_dut[i] = '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        dv = dut_vec(i);
        while (exp_q[i].size() > 0 && exp_q[i][0].edge_n < cyc) begin
          r = exp_q[i].pop_front();
          vectors++; miscompares++;
          $display("FAIL missing_change inst%0d edge %0d: DUT showed %h, required %h", i, r.edge_n, prev_dut[i], r.v);
        end
        if (dv != prev_dut[i]) begin
          vectors++;
          if (exp_q[i].size() == 0) begin
            miscompares++;
            $display("FAIL unexpected_change inst%0d edge %0d: got %h, required %h", i, cyc, dv, prev_dut[i]);
          end else begin
            r = exp_q[i].pop_front();
            if (r.edge_n != cyc || r.v != dv) begin
              miscompares++;
              $display("FAIL output_vector inst%0d: got %h at edge %0d, required %h at edge %0d",
                       i, dv, cyc, r.v, r.edge_n);
            end
          end
        end
        prev_dut[i] = dv;
      end
    end
  end

  task automatic step(logic fh, logic vh, logic fo, logic vo, logic fc, logic vc);
    @(negedge clk); #2;
    flag_half = fh; val_half = vh; flag_one = fo; val_one = vo; flag_cancel = fc; val_cancel = vc;
  endtask

  task automatic idle(int n);
    repeat (n) step(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
  endtask

  task automatic press(bit h, bit o, bit c);
    step(h, ~h, o, ~o, c, ~c);
    idle(2);
  endtask

  task automatic clear_all();
    idle(20);
    press(1'b0, 1'b0, 1'b1);
    idle(70);
  endtask

  task automatic chk_zero(string tag);
    vec_t v;
    for (int i = 0; i < 2; i++) begin
      v = dut_vec(i);
      vectors++;
      if (v != '0) begin
        miscompares++;
        $display("FAIL %s inst%0d: got %h, required 000", tag, i, v);
      end
    end
  endtask

  task automatic chk_credit(string tag, int id, int req);
    vec_t v;
    v = dut_vec(id);
    vectors++;
    if (v.credit != 8'(req)) begin
      miscompares++;
      $display("FAIL %s inst%0d: credit %0d, required %0d", tag, id, v.credit, req);
    end
  endtask

  initial begin
    logic [5:0] rs;
    repeat (3) @(negedge clk);
    chk_zero("reset_state");
    #2 rst_n = 1'b1;
    idle(3);

    // exact payment on A
    press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0); press(1'b1, 1'b0, 1'b0);
    clear_all();
    // overpayment on A
    press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0);
    clear_all();
    // cancel refund
    press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b0, 1'b1);
    clear_all();
    // simultaneous coins at credit 4
    press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0); press(1'b1, 1'b1, 1'b0);
    clear_all();
    // release strobes are ignored
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1); press(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1); step(1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
    idle(3);
    clear_all();
    // ceiling on B: climb to 19, reject a one, then half reaches MAX == PRICE_B
    repeat (9) begin
      press(1'b0, 1'b1, 1'b0);
      idle(8);
    end
    press(1'b1, 1'b0, 1'b0);
    chk_credit("credit_19", 1, 19);
    press(1'b0, 1'b1, 1'b0);
    chk_credit("ceiling_reject", 1, 19);
    press(1'b1, 1'b0, 1'b0);
    clear_all();
    // coin during dispense
    press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    idle(3);
    clear_all();
    // reset during CHANGE
    press(1'b1, 1'b0, 1'b0); press(1'b0, 1'b1, 1'b0); press(1'b0, 1'b0, 1'b1);
    @(negedge clk); #3 rst_n = 1'b0;
    #1 chk_zero("reset_in_change");
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    idle(3);
    // idle timeout
    press(1'b0, 1'b1, 1'b0);
    idle(100);
    chk_credit("timeout_a", 0, TMO_EN ? 0 : 2);
    chk_credit("timeout_b", 1, TMO_EN ? 0 : 2);
    clear_all();
    // randomized traffic
    for (int k = 0; k < 500; k++) begin
      if ($urandom_range(0, 2) == 0) begin
        rs = 6'($urandom);
        step(rs[5], rs[4], rs[3], rs[2], rs[1], rs[0]);
      end else begin
        idle(1);
      end
    end
    clear_all();
    idle(10);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (exp_q[i].size() != 0) begin
        miscompares++;
        $display("FAIL leftover_expect inst%0d: %0d pending, required 0", i, exp_q[i].size());
      end
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
